serial_rx_8: RTL and testbench
==============================

SERIAL_RX_8 -- requirements
Module: serial_rx_8

Interface
REQ-001 Parameter: W, default 8, the number of data bits per word.
REQ-002 Clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  is a synchronous, active-high reset.
REQ-004 Shift_In  input  1  carries the serial data bit, LSB first.
REQ-005 Shift_Valid  input  1  SHALL qualify Shift_In.
REQ-006 Shift_Ready  output  1  SHALL signal that the block can accept a bit this cycle.
REQ-007 Data_Out  output  W  SHALL carry the assembled parallel word.
REQ-008 Data_Valid  output  1  SHALL signal that Data_Out holds an unconsumed word.
REQ-009 Data_Ready  input  1  SHALL signal that the consumer accepts Data_Out this cycle.
REQ-010 Parity_Err  output  1  SHALL flag a parity error for the word on Data_Out.

Function
REQ-011 A bit SHALL be accepted on a rising edge where Shift_Valid=1 and Shift_Ready=1; no other edge shall change the shift register or the bit count.
REQ-012 An accepted bit SHALL enter the shift register at the MSB: sr <= {Shift_In, sr[W-1:1]}, so the first bit received ends in bit 0.
REQ-013 The FSM SHALL have three states:
- SHIFT: collecting bits.
- PAR: collecting the parity bit; this state exists only with the Configuration feature compiled in.
- HOLD: a complete word is in sr, but the output register is occupied.
REQ-014 The bit counter SHALL count 0..W-1 in SHIFT, SHALL wrap to 0 when a word completes, and SHALL never exceed W-1.
REQ-015 Completion, output register free (Data_Valid=0, or Data_Ready=1 on the same edge): the completing edge SHALL load Data_Out with the shifted value and set Data_Valid=1 in the next cycle (one-cycle latency); the FSM returns to SHIFT.
REQ-016 Completion, output register occupied and not consumed: the shifted value SHALL stay in sr and the FSM SHALL enter HOLD.
REQ-017 Shift_Ready SHALL be 1 in SHIFT and PAR, and 0 in HOLD.
REQ-018 In HOLD, the edge with Data_Ready=1 SHALL move sr (and its parity flag) into Data_Out, keep Data_Valid=1, and return the FSM to SHIFT.
REQ-019 A Data_Valid=1 and Data_Ready=1 edge with no word moving into Data_Out SHALL clear Data_Valid.
REQ-020 Data_Out and Parity_Err SHALL remain stable while Data_Valid=1 and Data_Ready=0.
REQ-021 Maximum buffering SHALL be two words (output register plus sr); no word shall ever be dropped or overwritten.
REQ-022 With continuous Shift_Valid and Data_Ready held at 1, throughput SHALL be one word per W cycles (W+1 with parity) with no Shift_Ready gaps.

Reset
REQ-023 Reset=1 at an edge SHALL set state=SHIFT, the bit count, sr and Data_Out to 0, Data_Valid=0, Parity_Err=0 and the stored parity flag to 0.
REQ-024 While Reset=1, Shift_Ready SHALL read 0.
REQ-025 Reset SHALL take priority over all other inputs.
REQ-026 Reset mid-word SHALL discard any partial word and any held word.

Configuration
REQ-027 The macro SERIAL_RX_PARITY_EN SHALL control the parity feature.
REQ-028 With SERIAL_RX_PARITY_EN defined:
- after W data bits the FSM enters PAR and accepts one extra bit;
- completion occurs on the parity-bit edge;
- the error flag is 1 when the XOR of the W data bits and the parity bit is 1 (even parity expected);
- the flag travels with its word into Parity_Err.
REQ-029 Without SERIAL_RX_PARITY_EN, the PAR state and the parity logic SHALL be absent, completion occurs on the W-th bit, and Parity_Err SHALL be tied to 0.

Structure
REQ-030 Package serial_rx_pkg SHALL hold the state enum (SHIFT, PAR, HOLD), the default W constant, and the counter width constant $clog2(W+1).
REQ-031 One sub-module, serial_rx_shreg, SHALL implement the W-bit MSB-in shift register with shift enable and synchronous clear; the FSM and output register SHALL reside in serial_rx_8.

Verification
REQ-032 Basic receive: after reset, send bits 1,0,1,0,0,1,0,1 with Data_Ready=1 -> Data_Out=8'hA5, Data_Valid=1 for exactly one cycle, one cycle after the 8th bit.
REQ-033 Back-pressure: Data_Ready=0, send 8'h3C then 8'hC3 -> Shift_Ready=0 after the second word; raising Data_Ready yields 3C, then C3, in order with nothing lost.
REQ-034 Throughput: stream 4 words with Shift_Valid=1 and Data_Ready=1 continuously -> Shift_Ready never drops, and Data_Valid pulses every 8 cycles (9 with parity).
REQ-035 Gapped input: Shift_Valid toggles 1/0 during 8'hFF -> the word completes only after the 8th accepted bit, and the count does not advance on Shift_Valid=0 cycles.
REQ-036 Reset mid-word: assert Reset after 4 bits of 8'h0F, then send 8'h81 -> Data_Out=8'h81 with no residue, and no spurious Data_Valid.
REQ-037 Parity (SERIAL_RX_PARITY_EN): send 8'h07 with parity bit 1 -> Parity_Err=0; send 8'h07 with parity bit 0 -> Parity_Err=1 alongside Data_Out=8'h07.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and sizing for the serial_rx_8 deserializer.
// The parity option is selected by the SERIAL_RX_PARITY_EN macro in serial_rx_8.
package serial_rx_pkg;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned CNT_W_DEF = $clog2(W_DEF + 1);

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    PAR   = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Bit-counter width for a W-bit word.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_rx_shreg.sv
// W-bit shift register: new bits enter at the MSB, so the first bit
// received ends up in bit 0. Synchronous clear has priority over shifting.
module serial_rx_shreg
  import serial_rx_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         Clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_sr
);

  logic [W-1:0] r_sr;

  always_ff @(posedge Clk) begin
    if (i_clr) begin
      r_sr <= '0;
    end else if (i_en) begin
      r_sr <= {i_bit, r_sr[W-1:1]};
    end
  end

  assign o_sr = r_sr;

endmodule

// File: rtl/serial_rx_8.sv
// Serial-to-parallel receiver, LSB first, with a two-word buffer (output register + sr).
// Define SERIAL_RX_PARITY_EN to append and check an even-parity bit per word.
module serial_rx_8
  import serial_rx_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Shift_In,
  input  logic         Shift_Valid,
  output logic         Shift_Ready,
  output logic [W-1:0] Data_Out,
  output logic         Data_Valid,
  input  logic         Data_Ready,
  output logic         Parity_Err
);

  localparam int unsigned CW = cnt_width(W);

  state_e       r_state;
  state_e       w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [W-1:0] r_dout;
  logic [W-1:0] w_dout_nx;
  logic         r_valid;
  logic         w_valid_nx;

  logic [W-1:0] w_sr;
  logic [W-1:0] w_done_word;
  logic         w_shift_en;
  logic         w_accept;
  logic         w_out_free;
  logic         w_done;

`ifdef SERIAL_RX_PARITY_EN
  logic r_par;
  logic w_par_nx;
  logic r_perr;
  logic w_perr_nx;
  logic r_herr;
  logic w_herr_nx;
  logic w_done_err;
`endif

  serial_rx_shreg #(.W(W)) u_shreg (
    .Clk   (Clk),
    .i_clr (Reset),
    .i_en  (w_shift_en),
    .i_bit (Shift_In),
    .o_sr  (w_sr)
  );

  assign Shift_Ready = ~Reset & (r_state != HOLD);
  assign w_accept    = Shift_Valid & Shift_Ready;
  assign w_out_free  = ~r_valid | Data_Ready;

  // With parity the word is already complete in sr; otherwise it includes this edge's bit.
`ifdef SERIAL_RX_PARITY_EN
  assign w_done_word = w_sr;
`else
  assign w_done_word = {Shift_In, w_sr[W-1:1]};
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= SHIFT;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
      r_herr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_dout  <= w_dout_nx;
      r_valid <= w_valid_nx;
`ifdef SERIAL_RX_PARITY_EN
      r_par   <= w_par_nx;
      r_perr  <= w_perr_nx;
      r_herr  <= w_herr_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_dout_nx  = r_dout;
    w_valid_nx = r_valid & ~Data_Ready;
    w_shift_en = 1'b0;
    w_done     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    w_par_nx   = r_par;
    w_perr_nx  = r_perr;
    w_herr_nx  = r_herr;
    w_done_err = 1'b0;
`endif

    case (r_state)
      SHIFT: begin
        if (w_accept) begin
          w_shift_en = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          w_par_nx = r_par ^ Shift_In;
`endif
          if (r_cnt == CW'(W - 1)) begin
            w_cnt_nx = '0;
`ifdef SERIAL_RX_PARITY_EN
            w_state_nx = PAR;
`else
            w_done = 1'b1;
`endif
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PAR: begin
        if (w_accept) begin
          w_done     = 1'b1;
          w_done_err = r_par ^ Shift_In;
          w_par_nx   = 1'b0;
        end
      end
`endif
      HOLD: begin
        if (Data_Ready) begin
          w_dout_nx  = w_sr;
          w_valid_nx = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          w_perr_nx  = r_herr;
`endif
          w_state_nx = SHIFT;
        end
      end
      default: w_state_nx = SHIFT;
    endcase

    // Word completion: load the output register if free, otherwise park in sr.
    if (w_done) begin
      if (w_out_free) begin
        w_dout_nx  = w_done_word;
        w_valid_nx = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        w_perr_nx  = w_done_err;
`endif
        w_state_nx = SHIFT;
      end else begin
`ifdef SERIAL_RX_PARITY_EN
        w_herr_nx  = w_done_err;
`endif
        w_state_nx = HOLD;
      end
    end
  end

  assign Data_Out   = r_dout;
  assign Data_Valid = r_valid;
`ifdef SERIAL_RX_PARITY_EN
  assign Parity_Err = r_perr;
`else
  assign Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_8.sv
// Directed bench for serial_rx_8 with a scoreboard queue of expected words.
// Parity steps are included when SERIAL_RX_PARITY_EN is defined.
module tb_serial_rx_8;

`ifdef SERIAL_RX_PARITY_EN
  localparam int BPW = 9;
`else
  localparam int BPW = 8;
`endif

  typedef struct {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  logic       Clk;
  logic       Reset;
  logic       Shift_In;
  logic       Shift_Valid;
  logic       Shift_Ready;
  logic [7:0] Data_Out;
  logic       Data_Valid;
  logic       Data_Ready;
  logic       Parity_Err;

  exp_t q[$];
  int   pop_cyc[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  serial_rx_8 #(.W(8)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Shift_In    (Shift_In),
    .Shift_Valid (Shift_Valid),
    .Shift_Ready (Shift_Ready),
    .Data_Out    (Data_Out),
    .Data_Valid  (Data_Valid),
    .Data_Ready  (Data_Ready),
    .Parity_Err  (Parity_Err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge Clk);
      cyc <= cyc + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every word taken by the consumer must match the oldest expectation.
  always @(negedge Clk) begin
    if (!Reset && Data_Valid && Data_Ready) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'(Data_Valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_data", 32'(Data_Out), 32'(e.data));
        check("sb_perr", 32'(Parity_Err), 32'(e.perr));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Shift_Valid = 1'b0;
    Shift_In    = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int n;
    Shift_In    = b;
    Shift_Valid = 1'b1;
    n = 0;
    while (!Shift_Ready && n < 100) begin
      tick();
      n++;
    end
    check("send_timeout", 32'(n < 100), 32'd1);
    tick();
  endtask

  task automatic send_word(input logic [7:0] d, input logic pbit);
    exp_t e;
    e.data = d;
`ifdef SERIAL_RX_PARITY_EN
    e.perr = (^d) ^ pbit;
`else
    e.perr = 1'b0;
`endif
    q.push_back(e);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    send_bit(pbit);
`endif
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    logic [7:0] w8;
    exp_t       e;
    int         t0;
    n_vec = 0;
    n_err = 0;
    Reset       = 1'b1;
    Shift_In    = 1'b0;
    Shift_Valid = 1'b0;
    Data_Ready  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_ready", 32'(Shift_Ready), 32'd0);
    check("rst_valid", 32'(Data_Valid), 32'd0);
    check("rst_data", 32'(Data_Out), 32'd0);
    check("rst_perr", 32'(Parity_Err), 32'd0);
    Reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(Shift_Ready), 32'd1);

    // Basic receive 8'hA5, one-cycle valid pulse
    Data_Ready = 1'b1;
    send_word(8'hA5, 1'b0);
    idle();
    check("basic_valid", 32'(Data_Valid), 32'd1);
    check("basic_data", 32'(Data_Out), 32'hA5);
    tick();
    check("basic_pulse", 32'(Data_Valid), 32'd0);

    // Back-pressure: two words buffered, then drained in order
    Data_Ready = 1'b0;
    send_word(8'h3C, 1'b0);
    send_word(8'hC3, 1'b0);
    idle();
    check("bp_ready", 32'(Shift_Ready), 32'd0);
    check("bp_data", 32'(Data_Out), 32'h3C);
    repeat (3) tick();
    check("bp_stable_data", 32'(Data_Out), 32'h3C);
    check("bp_stable_valid", 32'(Data_Valid), 32'd1);
    Data_Ready = 1'b1;
    wait_drain();
    tick();
    check("bp_valid_clr", 32'(Data_Valid), 32'd0);
    check("bp_ready_back", 32'(Shift_Ready), 32'd1);

    // Throughput: four words back to back
    pop_cyc.delete();
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      w8 = 8'h12 + 8'(k * 8'h22);
      send_word(w8, 1'(k));
    end
    idle();
    check("tp_cycles", 32'(cyc - t0), 32'(4 * BPW));
    wait_drain();
    check("tp_pops", 32'(pop_cyc.size()), 32'd4);
    for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
      check("tp_interval", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'(BPW));

    // Gapped input 8'hFF; idle cycles drive 0 so a counted gap would corrupt the word
    e.data = 8'hFF;
    e.perr = 1'b0;
    q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("gap_early", 32'(Data_Valid), 32'd0);
      send_bit(1'b1);
      idle();
      tick();
    end
`ifdef SERIAL_RX_PARITY_EN
    send_bit(1'b0);
    idle();
`endif
    wait_drain();

    // Reset mid-word, then a clean 8'h81
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    Reset = 1'b1;
    #1;
    check("midrst_ready", 32'(Shift_Ready), 32'd0);
    tick();
    tick();
    Reset = 1'b0;
    idle();
    #1;
    check("midrst_valid", 32'(Data_Valid), 32'd0);
    check("midrst_data", 32'(Data_Out), 32'd0);
    send_word(8'h81, 1'b0);
    idle();
    check("midrst_word", 32'(Data_Out), 32'h81);
    wait_drain();

`ifdef SERIAL_RX_PARITY_EN
    // Even parity: good then bad parity bit on 8'h07
    send_word(8'h07, 1'b1);
    idle();
    check("par_ok", 32'(Parity_Err), 32'd0);
    send_word(8'h07, 1'b0);
    idle();
    check("par_err", 32'(Parity_Err), 32'd1);
    check("par_data", 32'(Data_Out), 32'h07);
    wait_drain();
`else
    send_word(8'h07, 1'b0);
    idle();
    check("noparity_perr", 32'(Parity_Err), 32'd0);
    wait_drain();
`endif

    repeat (2) tick();
    check("sb_empty", 32'(q.size()), 32'd0);
    check("final_ready", 32'(Shift_Ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
